// File: rtl/qam16_pkg.sv
// Shared QAM-16 definitions: constellation levels, Gray mapping and rail slicer.
package qam16_pkg;

  localparam int SAMP_W = 15;

  typedef logic signed [2:0]        qam_lvl_t;
  typedef logic signed [SAMP_W-1:0] samp_t;

  localparam qam_lvl_t LVL_M3 = 3'b101;  // -3
  localparam qam_lvl_t LVL_M1 = 3'b111;  // -1
  localparam qam_lvl_t LVL_P1 = 3'b001;  // +1
  localparam qam_lvl_t LVL_P3 = 3'b011;  // +3

  // One sliced symbol: I and Q levels.
  typedef struct packed {
    qam_lvl_t i;
    qam_lvl_t q;
  } qam_sym_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_t;

  // Gray code per rail; adjacent levels differ in one bit.
  function automatic logic [1:0] gray2(input qam_lvl_t lvl);
    logic [1:0] g;
    case (lvl)
      LVL_M3:  g = 2'b00;
      LVL_M1:  g = 2'b01;
      LVL_P1:  g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  // Decide the nearest level; zero goes to +1, +/-thresh go to the outer levels.
  function automatic qam_lvl_t slice_lvl(input samp_t v, input int thresh);
    int x;
    qam_lvl_t l;
    x = int'(v);
    if (x >= thresh)      l = LVL_P3;
    else if (x >= 0)      l = LVL_P1;
    else if (x > -thresh) l = LVL_M1;
    else                  l = LVL_M3;
    return l;
  endfunction

endpackage

// File: rtl/qam16_sym_fifo.sv
// Small synchronous FIFO for demapped symbols; show-ahead output, push+pop
// allowed together even when full.
module qam16_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  // Head is forced to zero when empty so the output never shows stale storage.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and count; reset simply forgets any queued entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage, no reset needed since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/qam16_demod_slicer.sv
// QAM-16 receive slicer: symbol timing tracker, I/Q slicer, Gray demapper and
// output nibble FIFO.
module qam16_demod_slicer
  import qam16_pkg::*;
#(
  parameter int SPS        = 8,
  parameter int PHASE      = 4,
  parameter int THRESH     = 4096,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_MAX    = 16
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     filt_valid,
  input  logic signed [SAMP_W-1:0] filt_i,
  input  logic signed [SAMP_W-1:0] filt_q,
  output logic                     dout_valid,
  output logic [3:0]               dout,
  input  logic                     dout_ready,
  output logic signed [2:0]        mod_i,
  output logic signed [2:0]        mod_q,
  output logic                     locked,
  output logic                     overflow,
  output logic [15:0]              sym_cnt
);

  localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  trk_state_t       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d, cur_ph;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             slice_en;

  qam_sym_t         sym_q;
  logic [3:0]       nib_q;
  logic             push_q;
  logic [15:0]      sym_cnt_q;
  logic             ovf_q;

  qam_sym_t         sym_d;
  logic             fifo_full, fifo_empty, pop;

  // Tracker next-state: the first valid sample seen in IDLE is phase 0, so the
  // effective phase in IDLE is zero regardless of the (cleared) counter.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gap_d    = gap_q;
    slice_en = 1'b0;
    cur_ph   = (state_q == ST_TRACK) ? phase_q : '0;
    if (filt_valid) begin
      state_d  = ST_TRACK;
      gap_d    = '0;
      slice_en = (cur_ph == PH_W'(PHASE));
      phase_d  = (cur_ph == PH_W'(SPS - 1)) ? '0 : cur_ph + 1'b1;
    end else if (state_q == ST_TRACK) begin
      if (gap_q == GAP_W'(GAP_MAX - 1)) begin
        state_d = ST_IDLE;
        phase_d = '0;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // Tracker state register.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
    end
  end

  // Slicer decisions on the current sample.
  always_comb begin
    sym_d.i = slice_lvl(filt_i, THRESH);
    sym_d.q = slice_lvl(filt_q, THRESH);
  end

  // Register the sliced symbol, its nibble and a push strobe one cycle later;
  // a push into a full FIFO with no pop loses the symbol and latches overflow.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      sym_q     <= '0;
      nib_q     <= '0;
      push_q    <= 1'b0;
      sym_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      push_q <= slice_en;
      if (slice_en) begin
        sym_q     <= sym_d;
        nib_q     <= {gray2(sym_d.i), gray2(sym_d.q)};
        sym_cnt_q <= sym_cnt_q + 16'd1;
      end
      if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pop = dout_valid && dout_ready;

  qam16_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk_i   (axi_clk),
    .rst_i   (axi_rst),
    .push_i  (push_q),
    .din_i   (nib_q),
    .pop_i   (pop),
    .dout_o  (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dout_valid = !fifo_empty;
  assign mod_i      = sym_q.i;
  assign mod_q      = sym_q.q;
  assign locked     = (state_q == ST_TRACK);
  assign overflow   = ovf_q;
  assign sym_cnt    = sym_cnt_q;

endmodule

// File: tb/tb_qam16_demod_slicer.sv
// Directed bench for qam16_demod_slicer: vector table plus multi-cycle sequences.
module tb_qam16_demod_slicer;

  logic               axi_clk = 1'b0;
  logic               axi_rst, filt_valid, dout_ready;
  logic signed [14:0] filt_i, filt_q;
  logic               dout_valid, locked, overflow;
  logic [3:0]         dout;
  logic signed [2:0]  mod_i, mod_q;
  logic [15:0]        sym_cnt;

  int nchk = 0;
  int nerr = 0;
  logic [3:0] rx[$];

  typedef struct {
    int         i;
    int         q;
    int         mi;
    int         mq;
    logic [3:0] nib;
  } vec_t;

  vec_t vt[8];
  int   sq_i[6];
  int   sq_q[6];
  logic [3:0] sq_n[6];
  logic [3:0] lb[128];

  always #5 axi_clk = ~axi_clk;

  qam16_demod_slicer dut (
    .axi_clk    (axi_clk),
    .axi_rst    (axi_rst),
    .filt_valid (filt_valid),
    .filt_i     (filt_i),
    .filt_q     (filt_q),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .mod_i      (mod_i),
    .mod_q      (mod_q),
    .locked     (locked),
    .overflow   (overflow),
    .sym_cnt    (sym_cnt)
  );

  // Sink: record every accepted nibble.
  always @(negedge axi_clk)
    if (!axi_rst && dout_valid && dout_ready) rx.push_back(dout);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present inputs for one cycle, return just after the clock edge.
  task automatic cyc(input logic v, input int i, input int q);
    filt_valid = v;
    filt_i     = 15'(i);
    filt_q     = 15'(q);
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    axi_rst = 1'b1;
    idle(2);
    axi_rst = 1'b0;
  endtask

  task automatic symbol(input int i, input int q);
    for (int k = 0; k < 8; k++) cyc(1'b1, i, q);
  endtask

  task automatic wait_rx(input int n);
    for (int t = 0; t < 200 && rx.size() < n; t++) idle(1);
  endtask

  function automatic int g2l(input logic [1:0] g);
    case (g)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  initial begin
    int base, badlock, noise;
    logic [3:0] nib;

    vt[0] = '{5000, 5000, 3, 3, 4'b1010};
    vt[1] = '{0, -4096, 1, -3, 4'b1100};
    vt[2] = '{4096, -1, 3, -1, 4'b1001};
    vt[3] = '{4095, -4095, 1, -1, 4'b1101};
    vt[4] = '{-4097, 1, -3, 1, 4'b0011};
    vt[5] = '{-1, 16383, -1, 3, 4'b0110};
    vt[6] = '{-16384, -4096, -3, -3, 4'b0000};
    vt[7] = '{100, -100, 1, -1, 4'b1101};

    sq_i = '{6000, -6000, 2000, -2000, 6000, -6000};
    sq_q = '{6000, 2000, -2000, -6000, -6000, 6000};
    sq_n = '{4'b1010, 4'b0011, 4'b1101, 4'b0100, 4'b1000, 4'b0010};

    axi_rst = 1'b1; dout_ready = 1'b0;
    filt_valid = 1'b0; filt_i = '0; filt_q = '0;
    @(posedge axi_clk); #1;
    idle(1);
    axi_rst = 1'b0;

    // Reset state
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sym_cnt", int'(sym_cnt), 0);
    chk("rst_mod_i", int'(mod_i), 0);
    chk("rst_mod_q", int'(mod_q), 0);

    // Test 1: one symbol, latency of slice -> level -> FIFO output
    for (int k = 0; k < 5; k++) cyc(1'b1, 5000, 5000);
    chk("t1_sym_cnt_n1", int'(sym_cnt), 1);
    chk("t1_mod_i_n1", int'(mod_i), 3);
    chk("t1_mod_q_n1", int'(mod_q), 3);
    chk("t1_dout_valid_n1", int'(dout_valid), 0);
    cyc(1'b1, 5000, 5000);
    chk("t1_dout_valid_n2", int'(dout_valid), 1);
    chk("t1_dout_n2", int'(dout), 4'b1010);
    cyc(1'b1, 5000, 5000);
    cyc(1'b1, 5000, 5000);
    chk("t1_locked", int'(locked), 1);
    chk("t1_sym_cnt", int'(sym_cnt), 1);
    chk("t1_dout_held", int'(dout), 4'b1010);
    dout_ready = 1'b1;
    wait_rx(1);
    chk("t1_rx_count", rx.size(), 1);
    if (rx.size() >= 1) chk("t1_rx_nib", int'(rx[0]), 4'b1010);

    // Test 2: table of slicing boundaries
    do_reset();
    base = rx.size();
    for (int k = 0; k < 8; k++) begin
      symbol(vt[k].i, vt[k].q);
      chk($sformatf("t2_mod_i[%0d]", k), int'(mod_i), vt[k].mi);
      chk($sformatf("t2_mod_q[%0d]", k), int'(mod_q), vt[k].mq);
    end
    wait_rx(base + 8);
    chk("t2_rx_count", rx.size() - base, 8);
    for (int k = 0; k < 8 && base + k < rx.size(); k++)
      chk($sformatf("t2_dout[%0d]", k), int'(rx[base+k]), int'(vt[k].nib));
    chk("t2_sym_cnt", int'(sym_cnt), 8);

    // Test 3: modulator + filter loopback with junk off the slicing phase
    do_reset();
    base = rx.size();
    badlock = 0;
    for (int s = 0; s < 128; s++) begin
      nib = 4'($urandom_range(0, 15));
      lb[s] = nib;
      for (int k = 0; k < 8; k++) begin
        if (k == 4) begin
          noise = int'($urandom_range(0, 1000)) - 500;
          cyc(1'b1, g2l(nib[3:2]) * 2048 + noise, g2l(nib[1:0]) * 2048 - noise);
        end else begin
          cyc(1'b1, int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)));
        end
        if (!locked) badlock++;
      end
    end
    wait_rx(base + 128);
    chk("t3_rx_count", rx.size() - base, 128);
    for (int k = 0; k < 128 && base + k < rx.size(); k++)
      chk($sformatf("t3_dout[%0d]", k), int'(rx[base+k]), int'(lb[k]));
    chk("t3_unlocked_cycles", badlock, 0);
    chk("t3_overflow", int'(overflow), 0);

    // Test 4: stalled sink, overflow, in-order drain
    do_reset();
    dout_ready = 1'b0;
    for (int s = 0; s < 4; s++) symbol(sq_i[s], sq_q[s]);
    chk("t4_overflow_at4", int'(overflow), 0);
    chk("t4_head_at4", int'(dout), int'(sq_n[0]));
    symbol(sq_i[4], sq_q[4]);
    chk("t4_overflow_at5", int'(overflow), 1);
    symbol(sq_i[5], sq_q[5]);
    chk("t4_head_held", int'(dout), int'(sq_n[0]));
    chk("t4_valid_held", int'(dout_valid), 1);
    chk("t4_sym_cnt", int'(sym_cnt), 6);
    base = rx.size();
    dout_ready = 1'b1;
    wait_rx(base + 4);
    idle(4);
    chk("t4_rx_count", rx.size() - base, 4);
    for (int k = 0; k < 4 && base + k < rx.size(); k++)
      chk($sformatf("t4_dout[%0d]", k), int'(rx[base+k]), int'(sq_n[k]));
    chk("t4_drained", int'(dout_valid), 0);
    chk("t4_overflow_sticky", int'(overflow), 1);

    // Test 6: reset with three nibbles queued
    dout_ready = 1'b0;
    for (int s = 0; s < 3; s++) symbol(sq_i[s], sq_q[s]);
    chk("t6_queued", int'(dout_valid), 1);
    chk("t6_sym_cnt_pre", int'(sym_cnt), 9);
    axi_rst = 1'b1;
    idle(1);
    axi_rst = 1'b0;
    chk("t6_dout_valid", int'(dout_valid), 0);
    chk("t6_sym_cnt", int'(sym_cnt), 0);
    chk("t6_overflow", int'(overflow), 0);
    chk("t6_locked", int'(locked), 0);
    idle(2);
    chk("t6_still_empty", int'(dout_valid), 0);
    base = rx.size();
    dout_ready = 1'b1;
    symbol(-6000, -6000);
    wait_rx(base + 1);
    chk("t6_restart_count", rx.size() - base, 1);
    if (rx.size() > base) chk("t6_restart_nib", int'(rx[base]), 4'b0000);

    // Test 5: short gap keeps phase, GAP_MAX gap drops lock and restarts phase
    do_reset();
    base = rx.size();
    cyc(1'b1, 5000, 5000);
    cyc(1'b1, 5000, 5000);
    idle(15);
    chk("t5_locked_gap15", int'(locked), 1);
    cyc(1'b1, 5000, 5000);
    cyc(1'b1, 5000, 5000);
    cyc(1'b1, -5000, 2000);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5000, 5000);
    chk("t5_mod_i_a", int'(mod_i), -3);
    chk("t5_mod_q_a", int'(mod_q), 1);
    chk("t5_sym_cnt_a", int'(sym_cnt), 1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5000, 5000);
    idle(15);
    chk("t5_locked_before", int'(locked), 1);
    idle(1);
    chk("t5_locked_fall", int'(locked), 0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 5000, 5000);
    cyc(1'b1, 2000, -5000);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5000, 5000);
    chk("t5_relocked", int'(locked), 1);
    chk("t5_mod_i_b", int'(mod_i), 1);
    chk("t5_mod_q_b", int'(mod_q), -3);
    chk("t5_sym_cnt_b", int'(sym_cnt), 2);
    wait_rx(base + 2);
    chk("t5_rx_count", rx.size() - base, 2);
    if (rx.size() >= base + 2) begin
      chk("t5_dout0", int'(rx[base]), 4'b0011);
      chk("t5_dout1", int'(rx[base+1]), 4'b1100);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
